rv_alu: RTL and testbench



---
 rtl/rv_alu.sv | 105 ++++++++++
 tb/tb_rv_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu.sv
// rv_alu: registered 32-bit integer ALU for the RV32I execute stage.
// Decodes R-type funct3/funct7[5], registers the result into rd and
// derives the zero flag z from the registered value.
// Optional feature: define RV_ALU_SHIFT_EN to build SLL/SRL/SRA on a
// 5-stage barrel shifter; without it the shift encodings return zero
// and no shifter logic exists.
module rv_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] rd,
  output logic        z
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SLL  = 3'b001,
    OP_SLT  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_SRL  = 3'b101,
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } op_e;

  logic [31:0] rd_d;
  logic [31:0] rd_q;
  logic        alt;
  logic [31:0] add_sub_res;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] shift_res;

  // Only funct7[5] carries meaning; the remaining bits are deliberately dropped.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign alt         = funct7[5];
  assign add_sub_res = alt ? (rs1 - rs2) : (rs1 + rs2);
  assign slt_res     = $signed(rs1) < $signed(rs2);
  assign sltu_res    = rs1 < rs2;

`ifdef RV_ALU_SHIFT_EN
  // Left shifts reuse the right-shift stages by reversing bits on the way in and out.
  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  logic [4:0]  shamt;
  logic        shift_left;
  logic        shift_fill;
  logic [31:0] stage [6];

  assign shamt      = rs2[4:0];
  assign shift_left = (funct3 == OP_SLL);
  assign shift_fill = ~shift_left & alt & rs1[31];
  assign stage[0]   = shift_left ? reverse32(rs1) : rs1;

  // Each stage shifts right by 2^i when shamt[i] is set, filling with the sign for SRA.
  for (genvar i = 0; i < 5; i++) begin : g_shift_stage
    localparam int Sh = 1 << i;
    assign stage[i+1] = shamt[i] ? {{Sh{shift_fill}}, stage[i][31:Sh]} : stage[i];
  end

  assign shift_res = shift_left ? reverse32(stage[5]) : stage[5];
`else
  assign shift_res = 32'h0;
`endif

  // Select the operation result to be captured on the next rising edge.
  always_comb begin
    rd_d = 32'h0;
    case (op_e'(funct3))
      OP_ADD:  rd_d = add_sub_res;
      OP_SLL:  rd_d = shift_res;
      OP_SLT:  rd_d = {31'b0, slt_res};
      OP_SLTU: rd_d = {31'b0, sltu_res};
      OP_XOR:  rd_d = rs1 ^ rs2;
      OP_SRL:  rd_d = shift_res;
      OP_OR:   rd_d = rs1 | rs2;
      OP_AND:  rd_d = rs1 & rs2;
      default: rd_d = 32'h0;
    endcase
  end

  // Result register: cleared asynchronously by reset, otherwise loaded every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 32'h0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd = rd_q;
  assign z  = ~|rd_q;

endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: table-driven and randomized scoreboard bench for rv_alu.
// Shift expectations follow RV_ALU_SHIFT_EN so the same bench covers both builds.
module tb_rv_alu;

`ifdef RV_ALU_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SLL  = 3'b001;
  localparam logic [2:0] F_SLT  = 3'b010;
  localparam logic [2:0] F_SLTU = 3'b011;
  localparam logic [2:0] F_XOR  = 3'b100;
  localparam logic [2:0] F_SRL  = 3'b101;
  localparam logic [2:0] F_OR   = 3'b110;
  localparam logic [2:0] F_AND  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rd;
  logic        z;

  always #5 clk = ~clk;

  rv_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .z      (z)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Independent reference for the randomized back-to-back stream.
  function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] r;
    case (f3)
      F_ADD:   r = f7[5] ? a - b : a + b;
      F_SLL:   r = ShiftEn ? (a << b[4:0]) : 32'h0;
      F_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      F_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      F_XOR:   r = a ^ b;
      F_SRL:   r = ShiftEn ? (f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0])) : 32'h0;
      F_OR:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one operation on the falling edge and record what it should produce.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] exp);
    @(negedge clk);
    rs1    = a;
    rs2    = b;
    funct3 = f3;
    funct7 = f7;
    exp_q.push_back(exp);
  endtask

  // Sample just after the next rising edge and compare against the oldest expectation.
  task automatic checkOutput(input string name);
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("[TB] FAIL %s: scoreboard empty, got rd=%h", name, rd);
      return;
    end
    e = exp_q.pop_front();
    checkValue({name, " rd"}, rd, e);
    checkValue({name, " z"}, {31'b0, z}, {31'b0, (e == 32'h0)});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Vector table: {rs1, rs2, funct3, funct7, expected rd}
    vecs.push_back('{32'd8,        32'd3,  F_ADD,  7'h20, 32'd5});
    vecs.push_back('{32'd3,        32'd8,  F_ADD,  7'h20, 32'hFFFF_FFFB});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, F_ADD,  7'h00, 32'h0});
    vecs.push_back('{32'd8,        32'd3,  F_ADD,  7'h5F, 32'd11});
    vecs.push_back('{32'd8,        32'd3,  F_ADD,  7'h7F, 32'd5});
    vecs.push_back('{32'd8,        32'd3,  F_XOR,  7'h00, 32'd11});
    vecs.push_back('{32'd8,        32'd3,  F_XOR,  7'h20, 32'd11});
    vecs.push_back('{32'd20,       32'd30, F_OR,   7'h00, 32'd30});
    vecs.push_back('{32'd20,       32'd30, F_AND,  7'h00, 32'd20});
    vecs.push_back('{32'd5,        32'd10, F_AND,  7'h00, 32'd0});
    vecs.push_back('{32'h0000_F0F0, 32'h0000_FF00, F_AND, 7'h20, 32'h0000_F000});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, F_SLT,  7'h00, 32'd1});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, F_SLTU, 7'h00, 32'd0});
    vecs.push_back('{32'd20,       32'd20, F_SLT,  7'h00, 32'd0});
    vecs.push_back('{32'd1, 32'hFFFF_FFFF, F_SLT,  7'h20, 32'd0});
    vecs.push_back('{32'd1, 32'hFFFF_FFFF, F_SLTU, 7'h00, 32'd1});
    vecs.push_back('{32'd8,        32'd3,  F_SLL,  7'h00, ShiftEn ? 32'd64 : 32'h0});
    vecs.push_back('{32'd8,        32'd35, F_SLL,  7'h00, ShiftEn ? 32'd64 : 32'h0});
    vecs.push_back('{32'd8,        32'd3,  F_SLL,  7'h20, ShiftEn ? 32'd64 : 32'h0});
    vecs.push_back('{32'd1,        32'd31, F_SLL,  7'h00, ShiftEn ? 32'h8000_0000 : 32'h0});
    vecs.push_back('{32'h8000_0000, 32'd4, F_SRL,  7'h00, ShiftEn ? 32'h0800_0000 : 32'h0});
    vecs.push_back('{32'h8000_0000, 32'd4, F_SRL,  7'h20, ShiftEn ? 32'hF800_0000 : 32'h0});
    vecs.push_back('{32'h8000_0000, 32'd36, F_SRL, 7'h1F, ShiftEn ? 32'h0800_0000 : 32'h0});
    vecs.push_back('{32'h8000_0000, 32'd31, F_SRL, 7'h20, ShiftEn ? 32'hFFFF_FFFF : 32'h0});
    vecs.push_back('{32'h4000_0000, 32'd4, F_SRL,  7'h20, ShiftEn ? 32'h0400_0000 : 32'h0});
    vecs.push_back('{32'h0000_1234, 32'hFFFF_FFE0, F_SRL, 7'h00, ShiftEn ? 32'h0000_1234 : 32'h0});

    // Reset state before any clock edge.
    rst_n  = 1'b0;
    rs1    = 32'd1;
    rs2    = 32'd2;
    funct3 = F_ADD;
    funct7 = 7'h00;
    #2;
    checkValue("reset rd", rd, 32'h0);
    checkValue("reset z", {31'b0, z}, 32'd1);

    // rd must not capture while reset is held across an edge.
    @(posedge clk);
    #1;
    checkValue("reset hold rd", rd, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd1, 32'd2, F_ADD, 7'h00, 32'd3);
    checkOutput("pre-reset add");

    // Mid-cycle reset clears the nonzero result with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async reset rd", rd, 32'h0);
    checkValue("async reset z", {31'b0, z}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd20, 32'd30, F_ADD, 7'h00, 32'd50);
    checkOutput("post-reset add");

    // Table vectors, one per cycle with no gaps.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].f7, vecs[i].exp);
      checkOutput($sformatf("vec%0d", i));
    end

    // Back-to-back ADD, SUB, XOR, OR, AND with fixed operands.
    applyStimulus(32'd100, 32'd7, F_ADD, 7'h00, 32'd107);
    checkOutput("b2b add");
    applyStimulus(32'd100, 32'd7, F_ADD, 7'h20, 32'd93);
    checkOutput("b2b sub");
    applyStimulus(32'd100, 32'd7, F_XOR, 7'h00, 32'd99);
    checkOutput("b2b xor");
    applyStimulus(32'd100, 32'd7, F_OR,  7'h00, 32'd103);
    checkOutput("b2b or");
    applyStimulus(32'd100, 32'd7, F_AND, 7'h00, 32'd4);
    checkOutput("b2b and");

    // Randomized back-to-back stream checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      logic [6:0]  f7;
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom);
      applyStimulus(a, b, f3, f7, refModel(a, b, f3, f7));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
